qfrag_feeder: RTL

QFRAG_FEEDER -- requirements
Module: qfrag_feeder

---
 rtl/qfrag_feeder_pkg.sv | 22 ++
 rtl/qfrag_prescaler.sv | 33 +++
 rtl/qfrag_feeder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/qfrag_feeder_pkg.sv
// Shared types and constants for the Q_FRAG serial feeder.
// Holds the controller state encoding and the legal parameter ranges.
package qfrag_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESET = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int DIV_MIN   = 1;
    localparam int DIV_MAX   = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qfrag_prescaler.sv
// Bit-rate prescaler: counts 0..DIV-1 while enabled and flags the last count.
// tick is high whenever the count sits at DIV-1; the count then wraps to 0.
module qfrag_prescaler
    import qfrag_feeder_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count cycles between shifted bits, wrapping after DIV-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qfrag_feeder.sv
// Serialiser that loads a word into a downstream Q_FRAG flip-flop: it presets
// the flop with in_init (q_st / q_rt pulse), then shifts WIDTH bits through
// QDI with one q_en pulse per bit every DIV cycles, then pulses done.
// Optional build macro QFRAG_FEEDER_ABORT_EN adds an abort input that cancels
// a word in PRESET or SHIFT and clears the downstream flop with a q_rt pulse.
module qfrag_feeder
    import qfrag_feeder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_init,
`ifdef QFRAG_FEEDER_ABORT_EN
    input  logic             abort,
`endif
    output logic             q_en,
    output logic             q_ds,
    output logic             q_di,
    output logic             q_st,
    output logic             q_rt,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] WORD_END = BW'(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || DIV < DIV_MIN || DIV > DIV_MAX) begin : g_range
        $error("qfrag_feeder: WIDTH or DIV out of legal range");
    end

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             abort_req;

`ifdef QFRAG_FEEDER_ABORT_EN
    assign abort_req = abort && ((state == PRESET) || (state == SHIFT));
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Prescaler restarts during PRESET so the first bit lands DIV cycles into SHIFT.
    qfrag_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (QCK),
        .rst    (QRT),
        .clear  (state == PRESET),
        .enable (state == SHIFT),
        .tick   (tick)
    );

    // Controller FSM with registered Q_FRAG control outputs.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            q_en      <= 1'b0;
            q_ds      <= 1'b0;
            q_di      <= 1'b0;
            q_st      <= 1'b0;
            q_rt      <= 1'b0;
            done      <= 1'b0;
        end else begin
            q_en <= 1'b0;
            q_st <= 1'b0;
            q_rt <= 1'b0;
            done <= 1'b0;
            if (abort_req) begin
                // Cancel wins over any bit due this cycle; clear the downstream flop.
                state <= IDLE;
                q_rt  <= 1'b1;
                q_ds  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            shift_reg <= in_data;
                            bit_cnt   <= '0;
                            q_st      <= in_init;
                            q_rt      <= !in_init;
                            state     <= PRESET;
                        end
                    end
                    PRESET: begin
                        q_ds  <= 1'b1;
                        state <= SHIFT;
                    end
                    SHIFT: begin
                        if (bit_cnt == WORD_END) begin
                            // Last bit went out in the previous cycle.
                            q_ds  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (tick) begin
                            q_en    <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (LSB_FIRST != 0) begin
                                q_di      <= shift_reg[0];
                                shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
                            end else begin
                                q_di      <= shift_reg[WIDTH-1];
                                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
